// File: rtl/packet_cut_cfg_ctrl.sv
// Shadowed packet-cutter configuration, applied only between packets of the monitored stream.
// Define PACKET_CUT_CFG_CTRL_STATS_EN to build the packet/apply statistics counters.
module packet_cut_cfg_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH  = 32,
  parameter int C_S_AXIS_DATA_WIDTH = 256
) (
  input  logic                          axi_aclk,
  input  logic                          axi_reset,
  input  logic                          cfg_wr_en,
  input  logic                          cfg_cut_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_cut_len,
  output logic                          cfg_busy,
  output logic                          cfg_err,
  input  logic                          mon_tvalid,
  input  logic                          mon_tready,
  input  logic                          mon_tlast,
  output logic                          cut_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_offset,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_words,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_bytes,
  input  logic                          stat_clr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] stat_pkt_cnt,
  output logic [C_S_AXI_DATA_WIDTH-1:0] stat_upd_cnt
);
  localparam int DW         = C_S_AXI_DATA_WIDTH;
  localparam int WORD_SHIFT = $clog2(C_S_AXIS_DATA_WIDTH / 8);
  localparam logic [DW-1:0] WORD_MASK = DW'((1 << WORD_SHIFT) - 1);
  localparam logic [DW-1:0] MAX_LEN   = DW'(65535);

  typedef enum logic {GAP, IN_PKT} state_t;

  typedef struct packed {
    logic          en;
    logic [DW-1:0] offset;
    logic [DW-1:0] words;
    logic [DW-1:0] bytes;
  } cut_cfg_t;

  state_t   state;
  logic     pending;
  cut_cfg_t shadow, cur, new_cfg;

  logic          beat, tlast_beat, boundary, apply, len_bad, wr_ok;
  logic [DW-1:0] len_m1, k, shamt;

  assign beat       = mon_tvalid & mon_tready;
  assign tlast_beat = beat & mon_tlast;
  // Safe points: idle between packets, or the last beat of a packet.
  assign boundary   = ((state == GAP) && !mon_tvalid) || tlast_beat;
  assign apply      = pending & boundary;
  assign len_bad    = (cfg_cut_len == '0) || (cfg_cut_len > MAX_LEN);
  assign wr_ok      = cfg_wr_en & (~cfg_cut_en | ~len_bad);

  // k is the number of valid bytes in the final word (1..32); offset marks them MSB-first.
  always_comb begin
    len_m1         = cfg_cut_len - DW'(1);
    k              = (len_m1 & WORD_MASK) + DW'(1);
    shamt          = DW'(DW) - k;
    new_cfg.en     = cfg_cut_en;
    new_cfg.bytes  = cfg_cut_len;
    new_cfg.words  = len_m1 >> WORD_SHIFT;
    new_cfg.offset = {DW{1'b1}} << shamt;
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state   <= GAP;
      pending <= 1'b0;
      shadow  <= '0;
      cur     <= '{en: 1'b0, offset: '1, words: '0, bytes: '0};
      cfg_err <= 1'b0;
    end else begin
      case (state)
        GAP:     if (beat && !mon_tlast) state <= IN_PKT;
        IN_PKT:  if (tlast_beat) state <= GAP;
        default: state <= GAP;
      endcase

      cfg_err <= cfg_wr_en & ~wr_ok;

      // A write landing on the apply edge supersedes the older shadow contents.
      if (apply) begin
        cur     <= wr_ok ? new_cfg : shadow;
        pending <= 1'b0;
        if (wr_ok) shadow <= new_cfg;
      end else if (wr_ok) begin
        shadow  <= new_cfg;
        pending <= 1'b1;
      end
    end
  end

  assign cfg_busy   = pending;
  assign cut_en     = cur.en;
  assign cut_offset = cur.offset;
  assign cut_words  = cur.words;
  assign cut_bytes  = cur.bytes;

`ifdef PACKET_CUT_CFG_CTRL_STATS_EN
  logic [DW-1:0] pkt_cnt, upd_cnt;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_cnt <= '0;
      upd_cnt <= '0;
    end else if (stat_clr) begin
      pkt_cnt <= '0;
      upd_cnt <= '0;
    end else begin
      if (tlast_beat) pkt_cnt <= pkt_cnt + DW'(1);
      if (apply)      upd_cnt <= upd_cnt + DW'(1);
    end
  end

  assign stat_pkt_cnt = pkt_cnt;
  assign stat_upd_cnt = upd_cnt;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_pkt_cnt    = '0;
  assign stat_upd_cnt    = '0;
`endif

endmodule

// File: tb/tb_packet_cut_cfg_ctrl.sv
// Directed, table-driven bench for packet_cut_cfg_ctrl (both stats builds).
module tb_packet_cut_cfg_ctrl;
  logic        axi_aclk = 1'b0;
  logic        axi_reset = 1'b1;
  logic        cfg_wr_en = 1'b0, cfg_cut_en = 1'b0;
  logic [31:0] cfg_cut_len = '0;
  logic        cfg_busy, cfg_err;
  logic        mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic        cut_en;
  logic [31:0] cut_offset, cut_words, cut_bytes;
  logic        stat_clr = 1'b0;
  logic [31:0] stat_pkt_cnt, stat_upd_cnt;

  packet_cut_cfg_ctrl dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .cfg_wr_en(cfg_wr_en), .cfg_cut_en(cfg_cut_en), .cfg_cut_len(cfg_cut_len),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .cut_en(cut_en), .cut_offset(cut_offset), .cut_words(cut_words), .cut_bytes(cut_bytes),
    .stat_clr(stat_clr), .stat_pkt_cnt(stat_pkt_cnt), .stat_upd_cnt(stat_upd_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  int errs = 0;
  int checks = 0;

`ifdef PACKET_CUT_CFG_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        wr, en;
    logic [31:0] len;
    logic        v, r, l;
    logic        busy, err, cen;
    logic [31:0] words, bytes, off;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic wr, en, input logic [31:0] len, input logic v, r, l,
                              input logic busy, err, cen, input logic [31:0] words, bytes, off);
    vec_t x;
    x.wr = wr; x.en = en; x.len = len; x.v = v; x.r = r; x.l = l;
    x.busy = busy; x.err = err; x.cen = cen; x.words = words; x.bytes = bytes; x.off = off;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic busy, err, cen,
                         input logic [31:0] w, b, o);
    chk({tag, " busy"},   32'(cfg_busy),   32'(busy));
    chk({tag, " err"},    32'(cfg_err),    32'(err));
    chk({tag, " cut_en"}, 32'(cut_en),     32'(cen));
    chk({tag, " words"},  cut_words,       w);
    chk({tag, " bytes"},  cut_bytes,       b);
    chk({tag, " offset"}, cut_offset,      o);
  endtask

  task automatic drive(input logic wr, en, input logic [31:0] len, input logic v, r, l);
    cfg_wr_en = wr; cfg_cut_en = en; cfg_cut_len = len;
    mon_tvalid = v; mon_tready = r; mon_tlast = l;
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  initial begin
    // Expected cutter configurations used by the table.
    // A: L=100, B: L=64, C: cut_en=0 L=0, D: L=1, E: L=65535
    vt.push_back(mk(1,1,100,   0,0,0, 1,0, 0,32'h0,        32'd0,     32'hFFFF_FFFF));
    vt.push_back(mk(0,0,0,     0,0,0, 0,0, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(1,1,0,     0,0,0, 0,1, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(0,0,0,     0,0,0, 0,0, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(1,1,70000, 0,0,0, 0,1, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(0,0,0,     0,0,0, 0,0, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(0,0,0,     1,1,0, 0,0, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(1,1,64,    1,0,0, 1,0, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(0,0,0,     1,1,0, 1,0, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(0,0,0,     1,1,0, 1,0, 1,32'd3,        32'd100,   32'hF000_0000));
    vt.push_back(mk(0,0,0,     1,1,1, 0,0, 1,32'd1,        32'd64,    32'hFFFF_FFFF));
    vt.push_back(mk(1,0,0,     0,0,0, 1,0, 1,32'd1,        32'd64,    32'hFFFF_FFFF));
    vt.push_back(mk(0,0,0,     0,0,0, 0,0, 0,32'h07FF_FFFF,32'd0,     32'hFFFF_FFFF));
    vt.push_back(mk(0,0,0,     1,1,0, 0,0, 0,32'h07FF_FFFF,32'd0,     32'hFFFF_FFFF));
    vt.push_back(mk(1,1,33,    1,0,0, 1,0, 0,32'h07FF_FFFF,32'd0,     32'hFFFF_FFFF));
    vt.push_back(mk(1,1,1,     1,1,0, 1,0, 0,32'h07FF_FFFF,32'd0,     32'hFFFF_FFFF));
    vt.push_back(mk(0,0,0,     1,1,1, 0,0, 1,32'd0,        32'd1,     32'h8000_0000));
    vt.push_back(mk(0,0,0,     0,0,0, 0,0, 1,32'd0,        32'd1,     32'h8000_0000));
    vt.push_back(mk(1,1,100,   1,0,0, 1,0, 1,32'd0,        32'd1,     32'h8000_0000));
    vt.push_back(mk(1,1,64,    1,1,1, 0,0, 1,32'd1,        32'd64,    32'hFFFF_FFFF));
    vt.push_back(mk(0,0,0,     0,0,0, 0,0, 1,32'd1,        32'd64,    32'hFFFF_FFFF));
    vt.push_back(mk(1,1,65535, 0,0,0, 1,0, 1,32'd1,        32'd64,    32'hFFFF_FFFF));
    vt.push_back(mk(0,0,0,     0,0,0, 0,0, 1,32'd2047,     32'd65535, 32'hFFFF_FFFE));
    vt.push_back(mk(1,1,65536, 0,0,0, 0,1, 1,32'd2047,     32'd65535, 32'hFFFF_FFFE));
    vt.push_back(mk(0,0,0,     0,0,0, 0,0, 1,32'd2047,     32'd65535, 32'hFFFF_FFFE));

    // Reset values
    step();
    chk_all("reset", 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    chk("reset stat_pkt", stat_pkt_cnt, 32'd0);
    chk("reset stat_upd", stat_upd_cnt, 32'd0);
    axi_reset = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].wr, vt[i].en, vt[i].len, vt[i].v, vt[i].r, vt[i].l);
      step();
      chk_all($sformatf("row%0d", i), vt[i].busy, vt[i].err, vt[i].cen,
              vt[i].words, vt[i].bytes, vt[i].off);
    end

    // Table has 3 tlast beats and 6 applies.
    chk("table stat_pkt", stat_pkt_cnt, STATS ? 32'd3 : 32'd0);
    chk("table stat_upd", stat_upd_cnt, STATS ? 32'd6 : 32'd0);

    // Clear wins over a simultaneous tlast increment.
    drive(0, 0, 0, 1, 1, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr stat_pkt", stat_pkt_cnt, 32'd0);
    chk("clr stat_upd", stat_upd_cnt, 32'd0);
    drive(0, 0, 0, 1, 1, 1);
    step();
    chk("post-clr stat_pkt", stat_pkt_cnt, STATS ? 32'd1 : 32'd0);

    // Reset mid-packet with a write pending.
    drive(0, 0, 0, 1, 1, 0);
    step();
    drive(1, 1, 33, 1, 0, 0);
    step();
    chk("pre-rst busy", 32'(cfg_busy), 32'd1);
    drive(0, 0, 0, 1, 1, 0);
    #3 axi_reset = 1'b1;
    #1;
    chk_all("async-rst", 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    chk("async-rst stat_pkt", stat_pkt_cnt, 32'd0);
    chk("async-rst stat_upd", stat_upd_cnt, 32'd0);
    step();
    drive(0, 0, 0, 1, 0, 0);
    axi_reset = 1'b0;
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk_all("no-apply-after-rst", 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    // FSM must be in GAP: an idle-stream write applies on the next cycle.
    drive(1, 1, 33, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk_all("gap-after-rst wr", 1, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    step();
    chk_all("gap-after-rst apply", 0, 0, 1, 32'd1, 32'd33, 32'h8000_0000);
    chk("gap-after-rst stat_upd", stat_upd_cnt, STATS ? 32'd1 : 32'd0);

    // Unending packet keeps the write pending.
    drive(0, 0, 0, 1, 1, 0);
    step();
    drive(1, 1, 100, 1, 1, 0);
    step();
    drive(0, 0, 0, 1, 1, 0);
    repeat (5) step();
    chk_all("long-pkt", 1, 0, 1, 32'd1, 32'd33, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/packet_cut_cfg_ctrl.md
PACKET_CUT_CFG_CTRL -- requirements
Module: packet_cut_cfg_ctrl

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: width of the config and status words.
REQ-002 Parameter C_S_AXIS_DATA_WIDTH, default 256: monitored stream width; the byte math in REQ-015 is fixed to 32 bytes per word.
REQ-003 axi_aclk  in  1  sole clock; one clock, reset is asynchronous and active-high.
REQ-004 axi_reset  in  1  asynchronous, active-high reset.
REQ-005 cfg_wr_en  in  1  one-cycle write strobe from the register block.
REQ-006 cfg_cut_en  in  1  requested cut enable.
REQ-007 cfg_cut_len  in  32  requested kept length in bytes.
REQ-008 cfg_busy  out  1  a write is pending and not yet applied.
REQ-009 cfg_err  out  1  one-cycle pulse when a write is rejected.
REQ-010 mon_tvalid, mon_tready, mon_tlast  in  1 each  passive tap of the cutter's slave stream.
REQ-011 cut_en, cut_offset, cut_words, cut_bytes  out  1/32/32/32  registered cutter configuration.
REQ-012 stat_clr  in  1, stat_pkt_cnt  out  32, stat_upd_cnt  out  32  statistics (see REQ-026).

Function
REQ-013 Beat = mon_tvalid & mon_tready; the block never drives the stream.
REQ-014 Boundary FSM, states GAP and IN_PKT:
- GAP: beat without tlast -> IN_PKT; beat with tlast stays GAP (single-word packet).
- IN_PKT: beat with tlast -> GAP; otherwise stays.
REQ-015 Derived values for accepted length L:
- cut_bytes = L
- cut_words = (L-1)>>5
- k = ((L-1)&31)+1
- cut_offset = 32'hFFFF_FFFF << (32-k), so k=32 gives all ones and k=1 gives 32'h8000_0000.
REQ-016 Write acceptance:
- Write with L==0 or L>65535 is rejected: cfg_err pulses the next cycle; shadow and pending are unchanged.
- Write with cfg_cut_en=0 is always accepted, whatever L is.
REQ-017 An accepted write latches cfg_cut_en and the REQ-015 values into a shadow register and sets pending; a later write before apply overwrites the shadow, and only one apply follows.
REQ-018 Apply condition: pending and either (state GAP and mon_tvalid=0) or a tlast beat this cycle.
REQ-019 Apply effect:
- Shadow is copied to the cut_* outputs at that edge, so outputs change only between packets and are visible the cycle after.
- Pending clears at the same edge.
REQ-020 An accepted write in the same cycle as a true apply condition is applied directly at that edge, taking priority over the old shadow; pending ends cleared.
REQ-021 cfg_busy = pending, registered; it rises the cycle after an accepted write and falls the cycle after apply.
REQ-022 Back-to-back packets with no idle gap apply on the tlast beat; a stream that never ends a packet keeps pending set indefinitely.

Reset
REQ-023 Reset values:
- state GAP, pending 0, shadow 0
- cut_en 0, cut_words 0, cut_bytes 0, cut_offset 32'hFFFF_FFFF
- cfg_busy 0, cfg_err 0
- stat_pkt_cnt 0, stat_upd_cnt 0
REQ-024 Reset asserted mid-packet or with a write pending discards the pending write; after release the FSM is in GAP regardless of stream state.
REQ-025 All outputs are registered; none combinational from inputs.

Configuration
REQ-026 Macro PACKET_CUT_CFG_CTRL_STATS_EN defined:
- stat_pkt_cnt increments on every tlast beat; stat_upd_cnt increments on every apply.
- Both wrap 32'hFFFF_FFFF -> 0.
- stat_clr zeroes both at the next edge and wins over a simultaneous increment.
REQ-027 Macro undefined: counters are not built, stat outputs are tied to 0, stat_clr is ignored, and ports are identical in both builds.

Verification
REQ-028 Idle stream, write cut_en=1, L=100 -> next cycle busy=1; following cycle cut_words=3, cut_bytes=100, cut_offset=32'hF000_0000; busy falls with the apply.
REQ-029 Write L=64 mid-packet (IN_PKT, 3 beats left) -> outputs unchanged until the tlast beat, then cut_words=1, cut_offset=32'hFFFF_FFFF.
REQ-030 Write L=0, then L=70000 -> cfg_err pulses twice; outputs and busy unchanged.
REQ-031 Two writes (L=33 then L=1) during one packet -> a single apply at tlast with cut_words=0, cut_offset=32'h8000_0000; stat_upd_cnt +1.
REQ-032 Assert reset with a write pending mid-packet -> all outputs at REQ-023 values and no later apply; stats build: stat_pkt_cnt preset to 32'hFFFF_FFFF plus one tlast beat -> 0.
